// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through channels 0..3, dwells SETTLE
// cycles per channel, samples Y into a 4-bit snapshot and hands it off over
// valid/ready. Optional feature: define MUX_SCAN_NOSTALL_EN for non-stalling
// continuous mode with a sticky overrun flag.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    output logic [1:0] S,
    input  logic       Y,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] SETTLE_V = CW'(SETTLE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DWELL = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    shadow_q, shadow_d;
    logic [3:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
`ifdef MUX_SCAN_NOSTALL_EN
    logic          over_q, over_d;
`endif

    // Next-state and output logic for the scan sequencer
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q & ~ready;
`ifdef MUX_SCAN_NOSTALL_EN
        over_d   = over_q;
`endif
        case (state_q)
            ST_IDLE: begin
                s_d = 2'd0;
                if (start || cont) begin
                    state_d = ST_DWELL;
                    cnt_d   = SETTLE_V;
                end
            end
            ST_DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shadow_d[s_q] = Y;
                    if (s_q != 2'd3) begin
                        s_d   = s_q + 2'd1;
                        cnt_d = SETTLE_V;
                    end else begin
                        data_d  = {Y, shadow_q[2:0]};
                        valid_d = 1'b1;
`ifdef MUX_SCAN_NOSTALL_EN
                        // An unaccepted snapshot is being replaced
                        if (valid_q && !ready) over_d = 1'b1;
                        if (cont) begin
                            s_d   = 2'd0;
                            cnt_d = SETTLE_V;
                        end else begin
                            state_d = ST_HOLD;
                        end
`else
                        state_d = ST_HOLD;
`endif
                    end
                end
            end
            ST_HOLD: begin
                s_d = 2'd3;
                if (valid_q && ready) begin
                    s_d = 2'd0;
                    if (cont) begin
                        state_d = ST_DWELL;
                        cnt_d   = SETTLE_V;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 2'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= 2'd0;
            cnt_q    <= '0;
            shadow_q <= 4'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_NOSTALL_EN
            over_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef MUX_SCAN_NOSTALL_EN
            over_q   <= over_d;
`endif
        end
    end

    assign S     = s_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;
`ifdef MUX_SCAN_NOSTALL_EN
    assign overrun = over_q;
`else
    assign overrun = 1'b0;
`endif

endmodule
